// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Streams a big-endian program image (byte valid/ready) into the
//            unified instruction/data memory, holding the CPU until a load
//            finishes with a matching trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_wren,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_data,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            word_q, word_d;
    logic [COUNT_WIDTH-1:0] remain_q, remain_d;
    logic [7:0]             csum_q, csum_d;
    logic [1:0]             idx_q, idx_d;
    logic                   error_q, error_d;
    logic                   hold_q, hold_d;
    logic                   ready_q, ready_d;
    logic                   wren_q, wren_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Word addresses only: the two byte-offset bits of the base are dropped.
    logic [31:0] w_base_aligned;
    logic        w_accept;

    assign w_base_aligned = base_addr & 32'hFFFF_FFFC;
    // in_ready is itself a register, so the handshake sees exactly what the source sees.
    assign w_accept       = in_valid && ready_q;

    // Next-state and datapath updates; registered outputs follow the next state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        remain_d = remain_q;
        csum_d   = csum_q;
        idx_d    = idx_q;
        error_d  = error_q;
        hold_d   = hold_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = w_base_aligned;
                    remain_d = word_count;
                    csum_d   = 8'h00;
                    idx_d    = 2'd0;
                    error_d  = 1'b0;
                    hold_d   = 1'b1;
                    state_d  = (word_count == '0) ? S_CHECK : S_RECV;
                end
            end
            S_RECV: begin
                if (w_accept) begin
                    word_d = {word_q[23:0], in_data};
                    csum_d = csum_q ^ in_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d   = addr_q + 32'd4;
                remain_d = remain_q - COUNT_WIDTH'(1);
                idx_d    = 2'd0;
                state_d  = (remain_q == COUNT_WIDTH'(1)) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                if (w_accept) begin
                    error_d = (in_data != csum_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Release the CPU only when the image checked out.
                hold_d  = error_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
        wren_d  = (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset aborts any session and keeps the CPU held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0000_0000;
            word_q   <= 32'h0000_0000;
            remain_q <= '0;
            csum_q   <= 8'h00;
            idx_q    <= 2'd0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
            ready_q  <= 1'b0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            remain_q <= remain_d;
            csum_q   <= csum_d;
            idx_q    <= idx_d;
            error_q  <= error_d;
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            wren_q   <= wren_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign in_ready = ready_q;
    assign mem_wren = wren_q;
    assign mem_addr = addr_q;
    assign mem_data = word_q;
    assign cpu_hold = hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed self-checking bench for program_loader with an
//            image-level model of the expected memory writes and checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [15:0] word_count = 16'h0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_wren, cpu_hold, busy, done, error;
    logic [31:0] mem_addr, mem_data;

    program_loader #(.COUNT_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] shadow [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        prev_wren = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every write pulse must match the next write the image implies.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wren) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", mem_addr, mem_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (mem_addr !== e.a || mem_data !== e.d) begin
                        errors++;
                        $display("FAIL write: got 0x%08h@0x%08h expected 0x%08h@0x%08h", mem_data, mem_addr, e.d, e.a);
                    end
                end
                shadow[mem_addr] = mem_data;
                checks++;
                if (prev_wren) begin
                    errors++;
                    $display("FAIL wren_pulse: got 2+ cycles expected 1");
                end
                checks++;
                if (in_ready) begin
                    errors++;
                    $display("FAIL ready_in_write: got in_ready=1 expected 0");
                end
            end
            prev_wren = mem_wren;
        end else begin
            prev_wren = 1'b0;
        end
    end

    task automatic check_mem(input string name, input logic [31:0] a, input logic [31:0] exp);
        if (!shadow.exists(a)) begin
            checks++;
            errors++;
            $display("FAIL %s: got no write at 0x%08h expected 0x%08h", name, a, exp);
        end else begin
            chk(name, shadow[a], exp);
        end
    endtask

    task automatic start_session(input logic [31:0] b, input logic [15:0] n, output int t0);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        t0         = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: got no in_ready within %0d cycles expected acceptance", waited);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, output int t_end);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=0 expected done pulse");
            t_end = cyc;
        end else begin
            chk("done_error", {31'b0, error}, {31'b0, exp_err});
            @(posedge clk);
            #1;
            t_end = cyc;
            chk("done_pulse", {31'b0, done}, 32'd0);
            chk("hold_after", {31'b0, cpu_hold}, {31'b0, exp_err});
            chk("busy_after", {31'b0, busy}, 32'd0);
        end
    endtask

    // Model a whole session from the image, drive it, and return start-to-release cycles.
    task automatic run_load(input logic [31:0] base, input int n, input logic [7:0] img[$],
                            input logic [7:0] csum, input int maxgap, input logic do_ign,
                            output int lat);
        logic [7:0]  x;
        logic [31:0] a;
        int          t0, t1;
        x = 8'h00;
        a = base & 32'hFFFF_FFFC;
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.a = a + 32'(4 * w);
            e.d = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) x = x ^ img[4*w+k];
        end
        start_session(base, 16'(n), t0);
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_err_clr", {31'b0, error}, 32'd0);
        for (int i = 0; i < 4 * n; i++) begin
            send_byte(img[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (do_ign && i == 2) begin
                base_addr  = 32'h0000_1000;
                word_count = 16'd7;
                start      = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("ign_busy", {31'b0, busy}, 32'd1);
            end
        end
        send_byte(csum, 0);
        wait_done(csum != x, t1);
        lat = t1 - t0;
    endtask

    logic [7:0] img2[$] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    logic [7:0] none[$];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] x;

        // Model pin: XOR of the basic image is 0x25.
        x = 8'h00;
        foreach (img2[i]) x = x ^ img2[i];
        chk("model_csum", {24'b0, x}, 32'h25);

        reset = 1'b1;
        #1;
        chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic 2-word load, no stalls: 5N+3 = 13 cycles to release.
        run_load(32'h0, 2, img2, 8'h25, 0, 1'b0, lat);
        check_mem("basic_w0", 32'h0, 32'h2008_0005);
        check_mem("basic_w1", 32'h4, 32'h0000_0008);
        chk("basic_latency", 32'(lat), 32'd13);

        // Bad checksum: both words written, error sticky, CPU held.
        shadow.delete();
        run_load(32'h0, 2, img2, 8'h24, 0, 1'b0, lat);
        check_mem("bad_w0", 32'h0, 32'h2008_0005);
        check_mem("bad_w1", 32'h4, 32'h0000_0008);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_sticky", {31'b0, error}, 32'd1);
        chk("bad_hold", {31'b0, cpu_hold}, 32'd1);

        // Zero-count load; its start also clears the sticky error.
        run_load(32'h40, 0, none, 8'h00, 0, 1'b0, lat);

        // Gaps between bytes, valid held through WRITE.
        shadow.delete();
        run_load(32'h0, 2, img2, 8'h25, 3, 1'b0, lat);
        check_mem("gap_w0", 32'h0, 32'h2008_0005);
        check_mem("gap_w1", 32'h4, 32'h0000_0008);

        // Address wrap with unaligned low bits ignored.
        shadow.delete();
        run_load(32'hFFFF_FFFF, 2, img2, 8'h25, 0, 1'b0, lat);
        check_mem("wrap_w0", 32'hFFFF_FFFC, 32'h2008_0005);
        check_mem("wrap_w1", 32'h0, 32'h0000_0008);

        // Start mid-session with another base is ignored.
        shadow.delete();
        run_load(32'h200, 2, img2, 8'h25, 0, 1'b1, lat);
        check_mem("ign_w0", 32'h200, 32'h2008_0005);
        check_mem("ign_w1", 32'h204, 32'h0000_0008);

        // Reset after 6 bytes: first word written, everything returns to reset values.
        shadow.delete();
        begin
            wr_t e;
            int  t0;
            e.a = 32'h100;
            e.d = 32'h2008_0005;
            exp_q.push_back(e);
            start_session(32'h100, 16'd2, t0);
            for (int i = 0; i < 6; i++) send_byte(img2[i], 0);
            reset = 1'b1;
            #1;
            chk("mid_ready", {31'b0, in_ready}, 32'd0);
            chk("mid_wren", {31'b0, mem_wren}, 32'd0);
            chk("mid_addr", mem_addr, 32'd0);
            chk("mid_data", mem_data, 32'd0);
            chk("mid_hold", {31'b0, cpu_hold}, 32'd1);
            chk("mid_busy", {31'b0, busy}, 32'd0);
            chk("mid_done", {31'b0, done}, 32'd0);
            chk("mid_error", {31'b0, error}, 32'd0);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("post_hold", {31'b0, cpu_hold}, 32'd1);
            chk("post_busy", {31'b0, busy}, 32'd0);
            check_mem("mid_w0", 32'h100, 32'h2008_0005);
        end

        chk("writes_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Writes a program image into the unified instruction/data memory before the pipelined CPU runs. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through the memory's write port (write enable, byte address, write data). While a load is pending or has failed, the block holds the CPU stalled. After the words, a trailing XOR checksum byte is checked.

## Interface
Parameters:
- `COUNT_WIDTH`, 16: width of the word-count input; max image = 2^COUNT_WIDTH-1 words.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load session; honoured only in IDLE.
- `base_addr`  in  32  byte address of the first word; sampled when `start` is honoured; low 2 bits ignored (forced 0).
- `word_count`  in  COUNT_WIDTH  number of words in the image; sampled when `start` is honoured.
- `in_valid`  in  1  a byte is presented on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  the block accepts a byte this cycle.
- `mem_wren`  out  1  memory write enable; one-cycle pulse per word.
- `mem_addr`  out  32  memory byte address.
- `mem_data`  out  32  memory write data.
- `cpu_hold`  out  1  drives the CPU PC/pipeline-register enables low while 1.
- `busy`  out  1  a session is in progress.
- `done`  out  1  one-cycle pulse at the end of a session.
- `error`  out  1  checksum mismatch; sticky until the next honoured `start` or `reset`.

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE.
- **IDLE**
  - `start`=1 latches `{base_addr[31:2],2'b00}` into the address register and `word_count` into the remaining counter.
  - It also clears the checksum accumulator, byte index and `error`, and sets `cpu_hold`=1.
  - Next state is RECV, or CHECK if `word_count`==0.
- **RECV**
  - `in_ready`=1.
  - Each accepted byte (`in_valid`&&`in_ready`) shifts into the word register, first byte → bits [31:24].
  - Each accepted byte is XORed into the checksum and increments the byte index.
  - On the 4th byte → WRITE.
- **WRITE**
  - `mem_wren`=1, `mem_addr`=address register, `mem_data`=assembled word.
  - `in_ready`=0.
  - Exit actions: address += 4 (modulo 2^32, wraps), remaining -= 1, byte index = 0.
  - Next state is CHECK if remaining is now 0, otherwise RECV.
- **CHECK**
  - `in_ready`=1.
  - The accepted byte is compared with the accumulator: `error` = (byte != accumulator).
  - Next state DONE.
- **DONE**
  - `done`=1 for this cycle.
  - `cpu_hold` ← `error`: the CPU is released only on a good checksum.
  - Next state IDLE.
- `busy`=1 in RECV, WRITE, CHECK, DONE.
- `start` outside IDLE is ignored with no effect.
- `in_valid` with `in_ready`=0 is not consumed; the source holds the byte.
- A byte stream with no session pending (IDLE) is never accepted.

## Timing
- Reset values (asynchronous):
  - state IDLE
  - `in_ready`=0, `mem_wren`=0, `mem_addr`=0, `mem_data`=0
  - `cpu_hold`=1: the CPU stays held from power-up until the first good load.
  - `busy`=0, `done`=0, `error`=0
- Reset mid-session aborts immediately. The memory keeps any words already written, but the session is treated as failed and `cpu_hold` stays 1.
- All outputs are registered, driven from the state and datapath registers.
- `mem_wren` is asserted in the cycle after the edge that accepts the 4th byte of a word, for exactly 1 cycle. `mem_addr` and `mem_data` are stable during that cycle.
- Peak throughput is 5 cycles per word (4 byte cycles + 1 write cycle).
- `done` is asserted the cycle after the checksum byte is accepted.
- `cpu_hold` falls on the edge that leaves DONE.
- A good N-word load with no stalls takes 5N+3 cycles from `start` to `cpu_hold` low.
- `start` is accepted again in the cycle after DONE.

## Test plan
- **Basic 2-word load.** Reset, then `start` with base 0x00000000, count 2. Stream 20 08 00 05 00 00 00 08, then checksum 0x25. Required:
  - mem[0x0]=0x20080005, mem[0x4]=0x00000008
  - each `mem_wren` pulse lasts 1 cycle
  - `done` pulse with `error`=0, then `cpu_hold`=0
- **Bad checksum.** Same image with checksum 0x24. Both words are written; `done` with `error`=1; `cpu_hold` stays 1. A new `start` clears `error`.
- **Backpressure and gaps.** Insert random `in_valid`=0 gaps between bytes and keep `in_valid`=1 during the WRITE cycle. Required: the same memory contents as the basic load, with no byte lost or duplicated (`in_ready`=0 during WRITE).
- **Address wrap and zero-count load.**
  - Base 0xFFFFFFFC, count 2 → writes to 0xFFFFFFFC, then 0x00000000.
  - Count 0 with checksum 0x00 → no `mem_wren`, `done` with `error`=0.
- **Reset mid-load and ignored start.**
  - Assert `reset` after 6 bytes of a 2-word load → every output returns to its reset value, including `cpu_hold`=1.
  - During a session, pulse `start` with a different base → ignored; the original address sequence continues.
